xreg_access_ctrl: RTL and testbench
===================================

XREG_ACCESS_CTRL -- requirements
Module: xreg_access_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 bus_req  input  1  software access request; held high until bus_ack.
REQ-005 bus_we  input  1  1 = write, 0 = read; valid with bus_req.
REQ-006 bus_addr  input  2  field select 0..2; 3 = illegal.
REQ-007 bus_wdata  input  12  write data; valid with bus_req.
REQ-008 bus_ack  output  1  one-cycle completion pulse.
REQ-009 bus_rdata  output  12  read data, valid with bus_ack; 0 on writes and errors.
REQ-010 bus_err  output  1  one-cycle pulse with bus_ack on illegal address.
REQ-011 sw_rd  output  3  one-hot, one-cycle field read strobe.
REQ-012 sw_wr  output  3  one-hot, one-cycle field write strobe.
REQ-013 sw_wr_data  output  12  write data driven to fields; stable while a strobe is high.
REQ-014 field_rdata  input  12  current field values; field i occupies bits [4i+3:4i].
REQ-015 hw_req  input  3  one-cycle hardware update requests, one bit per field.
REQ-016 hw_pulse  output  3  one-cycle hardware update strobes forwarded to fields.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 FSM states SHALL be IDLE, ARB, RESP.
REQ-019 IDLE: bus_req=1 SHALL capture bus_we, bus_addr, bus_wdata; addr<=2 -> ARB; addr=3 -> RESP with error flag set.
REQ-020 ARB, target field i: if hw_req[i] or hw_pend[i] is set and starve_cnt<3, the hardware event SHALL win, starve_cnt increments, state stays ARB.
REQ-021 ARB, otherwise: the block SHALL drive sw_wr[i] (write) or sw_rd[i] (read) high for exactly one cycle, clear starve_cnt, and go to RESP.
REQ-022 starve_cnt SHALL be 2 bits and saturate at 3; at 3 the sw strobe SHALL issue regardless of hw requests (at most 3 stall cycles per access).
REQ-023 Read data SHALL be field_rdata[4i+3:4i], zero-extended to 12 bits, sampled in the same cycle sw_rd[i] is high (pre-clear value).
REQ-024 RESP: bus_ack SHALL be high one cycle (bus_err too if illegal), then -> IDLE; a new request SHALL be accepted no earlier than the cycle after bus_ack.
REQ-025 Normal latency SHALL be: bus_req sampled at cycle N -> strobe high at N+2 -> bus_ack high at N+3; error: bus_ack at N+2.
REQ-026 hw_pulse[j] SHALL be asserted one cycle after hw_req[j], or one cycle after hw_pend[j] is set, unless a sw strobe to field j is being issued in that cycle.
REQ-027 On conflict with a sw strobe to field j, hw_pend[j] SHALL be set (or held) and hw_pulse[j] SHALL be issued in the following cycle; sw_* and hw_pulse to the same field SHALL never be high together.
REQ-028 A new hw_req[j] arriving while hw_pend[j] is set SHALL merge into it; one hw_pulse[j] covers both.
REQ-029 hw events on fields other than the sw target SHALL never be delayed.
REQ-030 bus_req dropping before bus_ack is illegal; behaviour is unspecified.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, starve_cnt=0, hw_pend=0, and all outputs to 0.
REQ-032 Reset during ARB or RESP SHALL abort the access with no bus_ack and no strobe.
REQ-033 After rst_n deasserts, the first rising edge SHALL be able to accept bus_req.

Verification
REQ-034 Write addr=1, wdata=0x00A, no hw activity -> sw_wr=3'b010 with sw_wr_data=0x00A at N+2; bus_ack at N+3; bus_err=0.
REQ-035 Read addr=2, field_rdata=0x5A3 -> sw_rd=3'b100 at N+2; bus_ack at N+3 with bus_rdata=0x005.
REQ-036 Read addr=3 -> bus_ack and bus_err together at N+2; no sw_rd/sw_wr strobe; bus_rdata=0.
REQ-037 hw_req[0] high every cycle during a write to addr 0 -> exactly 3 stall cycles, then sw_wr=3'b001; no cycle with sw_wr[0] and hw_pulse[0] both high; hw_pulse[0] follows in the next cycle.
REQ-038 hw_req[1] pulses while a write to addr 0 is in progress -> hw_pulse[1] one cycle later, undelayed.
REQ-039 rst_n asserted in the cycle after ARB is entered -> all outputs 0 at once, no bus_ack; a fresh request after release completes normally.

Source files
------------

// File: rtl/xreg_access_ctrl.sv
// ---------------------------------------------------------------------------
// xreg_access_ctrl
//
// Puts one software bus port in front of three 4-bit register fields and
// arbitrates it against per-field hardware update requests. A software
// access is turned into a one-cycle read or write strobe to the selected
// field. A hardware update is forwarded as a one-cycle hw_pulse.
//
// Arbitration rules:
//   * A software access can be held off by hardware activity on its own
//     target field for at most 3 cycles.
//   * A hardware event never coincides with a software strobe on the same
//     field. A clashing event is parked in hw_pend and issued one cycle later.
//   * Hardware events on other fields always pass through undelayed.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   bus_req/we/addr  software request (held until bus_ack); addr 3 is illegal
//   bus_wdata        write data
//   bus_ack          one-cycle completion pulse
//   bus_err          pulses with bus_ack on an illegal address
//   bus_rdata        read data, valid with bus_ack
//   sw_rd, sw_wr     one-hot per-field software strobes
//   sw_wr_data       write data presented to the fields
//   field_rdata      current field values, field i at [4i+3:4i]
//   hw_req           one-cycle hardware update requests per field
//   hw_pulse         one-cycle hardware update strobes per field
// ---------------------------------------------------------------------------
module xreg_access_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [1:0]  bus_addr,
    input  logic [11:0] bus_wdata,
    output logic        bus_ack,
    output logic [11:0] bus_rdata,
    output logic        bus_err,
    output logic [2:0]  sw_rd,
    output logic [2:0]  sw_wr,
    output logic [11:0] sw_wr_data,
    input  logic [11:0] field_rdata,
    input  logic [2:0]  hw_req,
    output logic [2:0]  hw_pulse
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic        we_reg;
    logic [1:0]  addr_reg;
    logic [11:0] wdata_reg;
    logic        err_reg;
    logic [1:0]  starve_cnt;
    logic [2:0]  hw_pend;

    logic [2:0]  target_onehot;
    logic [2:0]  hw_evt;
    logic        sw_issue;
    logic [2:0]  issue_mask;
    logic [3:0]  field_nib;

    always_comb begin
        target_onehot = (addr_reg == 2'd3) ? 3'b000 : (3'b001 << addr_reg);
        // A freshly arriving request and a parked one are the same event.
        hw_evt        = hw_req | hw_pend;
        // The software strobe wins once the starvation counter has saturated.
        sw_issue      = (state == ARB) &&
                        !(((hw_evt & target_onehot) != 3'b000) && (starve_cnt != 2'd3));
        issue_mask    = sw_issue ? target_onehot : 3'b000;
        case (addr_reg)
            2'd0:    field_nib = field_rdata[3:0];
            2'd1:    field_nib = field_rdata[7:4];
            2'd2:    field_nib = field_rdata[11:8];
            default: field_nib = 4'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            we_reg     <= 1'b0;
            addr_reg   <= 2'd0;
            wdata_reg  <= 12'd0;
            err_reg    <= 1'b0;
            starve_cnt <= 2'd0;
            hw_pend    <= 3'b000;
            bus_ack    <= 1'b0;
            bus_err    <= 1'b0;
            bus_rdata  <= 12'd0;
            sw_rd      <= 3'b000;
            sw_wr      <= 3'b000;
            sw_wr_data <= 12'd0;
            hw_pulse   <= 3'b000;
        end else begin
            bus_ack   <= 1'b0;
            bus_err   <= 1'b0;
            bus_rdata <= 12'd0;
            sw_rd     <= 3'b000;
            sw_wr     <= 3'b000;
            // Events colliding with this cycle's software strobe are parked
            // and go out next cycle; everything else is forwarded now.
            hw_pulse  <= hw_evt & ~issue_mask;
            hw_pend   <= hw_evt & issue_mask;

            case (state)
                IDLE: begin
                    // bus_req is still high while bus_ack is shown; ignore it
                    // then so a finished access is not accepted twice.
                    if (bus_req && !bus_ack) begin
                        we_reg     <= bus_we;
                        addr_reg   <= bus_addr;
                        wdata_reg  <= bus_wdata;
                        err_reg    <= (bus_addr == 2'd3);
                        starve_cnt <= 2'd0;
                        state      <= (bus_addr == 2'd3) ? RESP : ARB;
                    end
                end
                ARB: begin
                    if (sw_issue) begin
                        if (we_reg) begin
                            sw_wr      <= target_onehot;
                            sw_wr_data <= wdata_reg;
                        end else begin
                            sw_rd      <= target_onehot;
                        end
                        starve_cnt <= 2'd0;
                        state      <= RESP;
                    end else if (starve_cnt != 2'd3) begin
                        starve_cnt <= starve_cnt + 2'd1;
                    end
                end
                RESP: begin
                    bus_ack <= 1'b1;
                    bus_err <= err_reg;
                    // Sampled while sw_rd is still high: the pre-clear value.
                    if (!we_reg && !err_reg) begin
                        bus_rdata <= {8'd0, field_nib};
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xreg_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_xreg_access_ctrl
//
// Structure of the bench:
//   * A driver issues bus accesses and pushes the expected response of each
//     one into a scoreboard queue.
//   * A hardware-request process drives hw_req according to a mode selector.
//   * A monitor follows the access-level rules for every clock edge:
//       - when an access is accepted
//       - how many stall cycles hardware events may cause
//       - where the strobe goes
//       - what the ack carries
//       - which hw_pulse bits must fire
//     It compares the DUT outputs against those rules.
// ---------------------------------------------------------------------------
module tb_xreg_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_req = 1'b0;
    logic        bus_we = 1'b0;
    logic [1:0]  bus_addr = 2'd0;
    logic [11:0] bus_wdata = 12'd0;
    logic [11:0] field_rdata = 12'd0;
    logic [2:0]  hw_req = 3'b000;
    logic        bus_ack;
    logic [11:0] bus_rdata;
    logic        bus_err;
    logic [2:0]  sw_rd;
    logic [2:0]  sw_wr;
    logic [11:0] sw_wr_data;
    logic [2:0]  hw_pulse;

    xreg_access_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .bus_err     (bus_err),
        .sw_rd       (sw_rd),
        .sw_wr       (sw_wr),
        .sw_wr_data  (sw_wr_data),
        .field_rdata (field_rdata),
        .hw_req      (hw_req),
        .hw_pulse    (hw_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [11:0] wdata;
        logic [11:0] rdata;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;

    // hw_req modes:
    //   0 = idle
    //   1 = sparse random on all fields
    //   2 = target field held high every cycle
    //   3 = random on non-target fields only
    int         hw_mode = 0;
    logic [1:0] hw_tgt = 2'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // hardware request generator
    initial begin
        logic [2:0] tmask;
        forever begin
            @(negedge clk);
            tmask = (hw_tgt == 2'd3) ? 3'b000 : (3'b001 << hw_tgt);
            case (hw_mode)
                1:       hw_req = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
                2:       hw_req = tmask;
                3:       hw_req = 3'($urandom_range(0, 7)) & ~tmask;
                default: hw_req = 3'b000;
            endcase
        end
    end

    // monitor / reference model
    initial begin
        int         phase;  // 0 waiting for request, 1 arbitrating, 2 responding
        int         stalls;
        exp_t       cur;
        logic [2:0] owed;
        logic [2:0] evt;
        logic [2:0] mask;
        logic [2:0] tgt;
        logic [2:0] exp_wr;
        logic [2:0] exp_rd;
        logic       exp_ack;
        logic       exp_err;
        logic [11:0] exp_rdata;
        logic       prev_ack;
        logic [2:0] one;
        phase = 0; stalls = 0; owed = 3'b000; prev_ack = 1'b0; one = 3'b001;
        cur = '{we: 1'b0, addr: 2'd0, wdata: 12'd0, rdata: 12'd0, err: 1'b0};
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                chk("reset_outputs",
                    {bus_ack, bus_err, bus_rdata, sw_rd, sw_wr, sw_wr_data, hw_pulse}, 32'd0);
                phase = 0; stalls = 0; owed = 3'b000; prev_ack = 1'b0;
            end else begin
                evt = hw_req | owed;
                mask = 3'b000; exp_wr = 3'b000; exp_rd = 3'b000;
                exp_ack = 1'b0; exp_err = 1'b0; exp_rdata = 12'd0;
                case (phase)
                    0: begin
                        if (bus_req && !prev_ack) begin
                            if (sbq.size() == 0) begin
                                chk("unexpected_accept", 32'd1, 32'd0);
                            end else begin
                                cur = sbq.pop_front();
                                phase = cur.err ? 2 : 1;
                                stalls = 0;
                            end
                        end
                    end
                    1: begin
                        tgt = one << cur.addr;
                        if (((evt & tgt) != 3'b000) && stalls < 3) begin
                            stalls++;
                        end else begin
                            mask = tgt;
                            if (cur.we) exp_wr = tgt;
                            else        exp_rd = tgt;
                            phase = 2;
                        end
                    end
                    default: begin
                        exp_ack = 1'b1;
                        exp_err = cur.err;
                        exp_rdata = cur.rdata;
                        phase = 0;
                    end
                endcase
                chk("sw_wr", sw_wr, exp_wr);
                chk("sw_rd", sw_rd, exp_rd);
                chk("bus_ack", bus_ack, exp_ack);
                chk("bus_err", bus_err, exp_err);
                chk("bus_rdata", bus_rdata, exp_rdata);
                chk("hw_pulse", hw_pulse, evt & ~mask);
                chk("sw_hw_overlap", (sw_wr | sw_rd) & hw_pulse, 32'd0);
                if (exp_wr != 3'b000) chk("sw_wr_data", sw_wr_data, cur.wdata);
                owed = evt & mask;
                prev_ack = bus_ack;
            end
        end
    end

    function automatic exp_t mk_exp(input logic we, input logic [1:0] addr,
                                    input logic [11:0] wdata, input logic [11:0] fr);
        exp_t e;
        e.we = we;
        e.addr = addr;
        e.wdata = wdata;
        e.err = (addr == 2'd3);
        e.rdata = (!we && addr != 2'd3) ? ((fr >> (4 * addr)) & 12'h00F) : 12'd0;
        return e;
    endfunction

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus_ack && n < 20);
        chk(name, bus_ack, 32'd1);
        $display("txn we=%0d addr=%0d wdata=%03h rdata=%03h err=%0d cycles=%0d",
                 bus_we, bus_addr, bus_wdata, bus_rdata, bus_err, n);
        @(negedge clk);
        bus_req = 1'b0;
    endtask

    task automatic do_txn(input logic we, input logic [1:0] addr,
                          input logic [11:0] wdata, input logic [11:0] fr);
        @(negedge clk);
        field_rdata = fr;
        bus_we = we;
        bus_addr = addr;
        bus_wdata = wdata;
        hw_tgt = addr;
        sbq.push_back(mk_exp(we, addr, wdata, fr));
        bus_req = 1'b1;
        wait_ack("ack_timeout");
    endtask

    // Reset one cycle into arbitration, then request on the first edge after release.
    task automatic reset_mid_access();
        @(negedge clk);
        hw_mode = 1;
        field_rdata = 12'h3C7;
        bus_we = 1'b1;
        bus_addr = 2'd1;
        bus_wdata = 12'h055;
        hw_tgt = 2'd1;
        sbq.push_back(mk_exp(1'b1, 2'd1, 12'h055, 12'h3C7));
        bus_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            {bus_ack, bus_err, bus_rdata, sw_rd, sw_wr, sw_wr_data, hw_pulse}, 32'd0);
        bus_req = 1'b0;
        hw_mode = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_we = 1'b0;
        bus_addr = 2'd0;
        hw_tgt = 2'd0;
        sbq.push_back(mk_exp(1'b0, 2'd0, 12'd0, 12'h3C7));
        bus_req = 1'b1;
        wait_ack("post_reset_ack");
    endtask

    initial begin
        int m;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        do_txn(1'b1, 2'd1, 12'h00A, 12'h123);
        do_txn(1'b0, 2'd2, 12'h000, 12'h5A3);
        do_txn(1'b0, 2'd3, 12'h000, 12'hFFF);
        hw_mode = 2;
        do_txn(1'b1, 2'd0, 12'h7E1, 12'h000);
        hw_mode = 3;
        do_txn(1'b1, 2'd0, 12'h2B4, 12'h000);
        hw_mode = 0;
        reset_mid_access();

        for (int i = 0; i < 150; i++) begin
            m = $urandom_range(0, 3);
            hw_mode = m;
            do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
        end
        hw_mode = 0;
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
